// File: rtl/tone_pkg.sv
// Shared definitions for the note tone generator.
// Holds the octave-0 half-period table for a 100 MHz clock, the note/octave
// range limits, and the FSM state encoding used by note_tone_gen.
package tone_pkg;

  localparam int NOTES_PER_OCT = 12;
  localparam int MAX_OCT       = 5;
  localparam int BASE_W        = 20;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Half-period in 100 MHz clock cycles for C2..B2; higher octaves are
  // derived by right-shifting. Out-of-range notes return 0 and are flagged
  // separately by the lookup.
  function automatic logic [BASE_W-1:0] base_half(input logic [3:0] note);
    logic [BASE_W-1:0] val;
    case (note)
      4'd0:    val = 20'd764452;
      4'd1:    val = 20'd721544;
      4'd2:    val = 20'd681049;
      4'd3:    val = 20'd642824;
      4'd4:    val = 20'd606745;
      4'd5:    val = 20'd572691;
      4'd6:    val = 20'd540549;
      4'd7:    val = 20'd510210;
      4'd8:    val = 20'd481573;
      4'd9:    val = 20'd454545;
      4'd10:   val = 20'd429034;
      4'd11:   val = 20'd404955;
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational half-period lookup.
// Ports:
//   octave    in  3      octave 0..5
//   note      in  4      semitone 0..11
//   half      out CNT_W  half-period in clock cycles, never 0
//   range_err out 1      note or octave outside the playable range
module note_period_lut
  import tone_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int SIM_SHIFT = 0
) (
  input  logic [2:0]       octave,
  input  logic [3:0]       note,
  output logic [CNT_W-1:0] half,
  output logic             range_err
);

  logic [BASE_W-1:0] shifted;
  logic [CNT_W-1:0]  trunc;

  // A zero half-period would stall the counter reload, so very high
  // pitches (or large SIM_SHIFT) are clamped to the fastest toggle rate.
  always_comb begin
    range_err = (note >= 4'(NOTES_PER_OCT)) || (octave > 3'(MAX_OCT));
    shifted   = (base_half(note) >> octave) >> SIM_SHIFT;
    trunc     = CNT_W'(shifted);
    half      = (trunc == '0) ? CNT_W'(1) : trunc;
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator.
// Turns an {octave, note} request into a 50% duty audio bit. Pitch changes
// and note-off only take effect on a half-period boundary so the output
// never carries a runt pulse.
// Ports:
//   clk         in  1  100 MHz system clock
//   rst_n       in  1  asynchronous active-low reset
//   note_valid  in  1  request present on octave/note
//   note_ready  out 1  request accepted when note_valid & note_ready
//   octave      in  3  octave 0..5
//   note        in  4  semitone 0..11
//   note_off    in  1  single-cycle stop request
//   audio_out   out 1  square wave
//   active      out 1  high while a tone is playing
//   bad_note    out 1  one-cycle pulse after an out-of-range request
module note_tone_gen
  import tone_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int SIM_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [2:0] octave,
  input  logic [3:0] note,
  input  logic       note_off,
  output logic       audio_out,
  output logic       active,
  output logic       bad_note
);

  state_e           state_q, state_d;
  logic             audio_q, audio_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pending_q, pending_d;
  logic             stop_q, stop_d;
  logic             bad_q, bad_d;

  logic [CNT_W-1:0] lut_half;
  logic             range_err;
  logic             accept;
  logic             good_req;
  logic             take_req;
  logic             boundary;

  note_period_lut #(
    .CNT_W    (CNT_W),
    .SIM_SHIFT(SIM_SHIFT)
  ) u_lut (
    .octave   (octave),
    .note     (note),
    .half     (lut_half),
    .range_err(range_err)
  );

  assign note_ready = !pending_q;
  assign audio_out  = audio_q;
  assign active     = (state_q == PLAY);
  assign bad_note   = bad_q;

  // Next-state logic. In PLAY a fresh in-range request without a
  // simultaneous note_off cancels any stop that is waiting, which is why the
  // stop branch is gated by take_req. A note_off in the same cycle as a
  // request wins and the request is simply dropped.
  always_comb begin
    state_d     = state_q;
    audio_d     = audio_q;
    count_d     = count_q;
    cur_half_d  = cur_half_q;
    pend_half_d = pend_half_q;
    pending_d   = pending_q;
    stop_d      = stop_q;
    accept      = note_valid && !pending_q;
    good_req    = accept && !range_err;
    bad_d       = accept && range_err;
    take_req    = good_req && !note_off;
    boundary    = (count_q == '0);

    case (state_q)
      IDLE: begin
        if (good_req) begin
          state_d    = PLAY;
          audio_d    = 1'b1;
          count_d    = lut_half - CNT_W'(1);
          cur_half_d = lut_half;
          stop_d     = 1'b0;
          pending_d  = 1'b0;
        end
      end

      PLAY: begin
        count_d = count_q - CNT_W'(1);
        if (boundary && stop_q && !take_req) begin
          state_d   = IDLE;
          audio_d   = 1'b0;
          count_d   = '0;
          stop_d    = 1'b0;
          pending_d = 1'b0;
        end else begin
          if (boundary) begin
            audio_d = !audio_q;
            if (pending_q) begin
              count_d    = pend_half_q - CNT_W'(1);
              cur_half_d = pend_half_q;
              pending_d  = 1'b0;
            end else begin
              count_d = cur_half_q - CNT_W'(1);
            end
          end
          // Requests seen on the boundary cycle land in pending and apply at
          // the following boundary, never the current one.
          if (note_off) begin
            stop_d = 1'b1;
          end else if (take_req) begin
            pending_d   = 1'b1;
            pend_half_d = lut_half;
            stop_d      = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      audio_q     <= 1'b0;
      count_q     <= '0;
      cur_half_q  <= '0;
      pend_half_q <= '0;
      pending_q   <= 1'b0;
      stop_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      audio_q     <= audio_d;
      count_q     <= count_d;
      cur_half_q  <= cur_half_d;
      pend_half_q <= pend_half_d;
      pending_q   <= pending_d;
      stop_q      <= stop_d;
      bad_q       <= bad_d;
    end
  end

endmodule
